// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared prescaler and period counter,
// per-channel shadowed duties, edge- or center-aligned operation.
module pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int N        = 8,
  parameter int PRESCALE = 47,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          center_mode,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] wr_channel,
  input  logic [N-1:0]  wr_duty,
  output logic          wr_err,
  output logic          period_start,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  MAX     = '1;
  localparam logic [N-1:0]  TOP     = MAX - 1'b1;
  localparam logic [CW:0]   CH_LIM  = (CW+1)'(CHANNELS);

  logic [PW-1:0] presc;
  logic [N-1:0]  counter;
  logic          dir_down;
  logic          mode;
  logic [N-1:0]  pending [CHANNELS];
  logic [N-1:0]  active  [CHANNELS];

  logic          tick;
  logic          bnd;
  logic [N-1:0]  cnt_nxt;
  logic          dir_nxt;
  logic          wr_fire;
  logic          wr_ok;
  logic          reload;

  assign tick    = (presc == PS_LAST);
  assign wr_fire = wr_valid & wr_ready;
  assign wr_ok   = ({1'b0, wr_channel} < CH_LIM);
  assign reload  = ~ena | bnd;

  // Next counter state; bnd marks the edge that restarts the period.
  always_comb begin
    cnt_nxt = counter;
    dir_nxt = dir_down;
    bnd     = 1'b0;
    if (tick) begin
      unique case (1'b1)
        !mode: begin
          if (counter == TOP) bnd = 1'b1;
          else cnt_nxt = counter + 1'b1;
        end
        mode && !dir_down: begin
          if (counter == TOP) dir_nxt = 1'b1;
          else cnt_nxt = counter + 1'b1;
        end
        mode && dir_down: begin
          if (counter == '0) bnd = 1'b1;
          else cnt_nxt = counter - 1'b1;
        end
        default: ;
      endcase
      if (bnd) begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      counter  <= '0;
      dir_down <= 1'b0;
    end else if (!ena) begin
      presc    <= '0;
      counter  <= '0;
      dir_down <= 1'b0;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      counter  <= cnt_nxt;
      dir_down <= dir_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (reload) mode <= center_mode;
      period_start <= ena & bnd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_ready <= 1'b1;
      wr_err   <= wr_fire & ~wr_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_fire && wr_ok && wr_channel == CW'(i))
          pending[i] <= wr_duty;
      end
    end
  end

  // Active duties see the pre-edge pending value on a reload edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= '0;
      end
    end else if (reload) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= pending[i];
      end
    end
  end

  // Center mode mirrors the compare so the high run straddles the peak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!ena)
          pwm_out[i] <= 1'b0;
        else if (mode)
          pwm_out[i] <= (counter >= (MAX - active[i]));
        else
          pwm_out[i] <= (counter < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: period/duty vector table plus
// hand-written sequences for shadow update, errors, ena and reset.
module tb_pwm_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_ena = 1'b1, a_cm = 1'b0, a_wv = 1'b0;
  logic [1:0] a_wch = '0;
  logic [3:0] a_wd = '0;
  logic       a_rdy, a_err, a_ps;
  logic [2:0] a_pwm;

  logic       b_ena = 1'b1, b_cm = 1'b0, b_wv = 1'b0;
  logic [0:0] b_wch = '0;
  logic [3:0] b_wd = '0;
  logic       b_rdy, b_err, b_ps;
  logic [1:0] b_pwm;

  pwm_bank #(.CHANNELS(3), .N(4), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(a_ena), .center_mode(a_cm),
    .wr_valid(a_wv), .wr_ready(a_rdy), .wr_channel(a_wch),
    .wr_duty(a_wd), .wr_err(a_err), .period_start(a_ps),
    .pwm_out(a_pwm)
  );

  pwm_bank #(.CHANNELS(2), .N(4), .PRESCALE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(b_ena), .center_mode(b_cm),
    .wr_valid(b_wv), .wr_ready(b_rdy), .wr_channel(b_wch),
    .wr_duty(b_wd), .wr_err(b_err), .period_start(b_ps),
    .pwm_out(b_pwm)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_a(input logic [1:0] ch, input logic [3:0] d,
                         output logic err);
    @(negedge clk);
    a_wv = 1'b1; a_wch = ch; a_wd = d;
    @(negedge clk);
    a_wv = 1'b0;
    err = a_err;
  endtask

  task automatic write_b(input logic [0:0] ch, input logic [3:0] d);
    @(negedge clk);
    b_wv = 1'b1; b_wch = ch; b_wd = d;
    @(negedge clk);
    b_wv = 1'b0;
  endtask

  task automatic sync_a(input string name);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (a_ps) found = 1;
    end
    chk(name, int'(found), 1);
  endtask

  task automatic sync_b(input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (b_ps) found = 1;
    end
    chk(name, int'(found), 1);
  endtask

  // Counts one period: samples after a period_start up to the next one.
  task automatic measure_a(input int wr_at, input logic [3:0] wr_val,
                           output int per, output int h0, output int h1,
                           output int h2, output int first);
    bit done = 0;
    per = 0; h0 = 0; h1 = 0; h2 = 0; first = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      per++;
      if (wr_at != 0 && per == wr_at + 1) a_wv = 1'b0;
      if (wr_at != 0 && per == wr_at) begin
        a_wv = 1'b1; a_wch = 2'd0; a_wd = wr_val;
      end
      if (a_pwm[0]) begin
        h0++;
        if (first == 0) first = per;
      end
      if (a_pwm[1]) h1++;
      if (a_pwm[2]) h2++;
      if (a_ps) done = 1;
    end
    a_wv = 1'b0;
    if (!done) chk("measure_a_timeout", 0, 1);
  endtask

  task automatic measure_b(output int per, output int h0);
    bit done = 0;
    per = 0; h0 = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      per++;
      if (b_pwm[0]) h0++;
      if (b_ps) done = 1;
    end
    if (!done) chk("measure_b_timeout", 0, 1);
  endtask

  typedef struct {
    logic       center;
    logic [3:0] duty;
    int         per;
    int         hi;
    int         first;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int per, h0, h1, h2, first, cnt, psn;
    logic err;

    tbl[0] = '{1'b0, 4'd5,  15, 5,  1};
    tbl[1] = '{1'b0, 4'd0,  15, 0,  0};
    tbl[2] = '{1'b0, 4'd15, 15, 15, 1};
    tbl[3] = '{1'b0, 4'd1,  15, 1,  1};
    tbl[4] = '{1'b0, 4'd14, 15, 14, 1};
    tbl[5] = '{1'b1, 4'd4,  30, 8,  12};
    tbl[6] = '{1'b1, 4'd0,  30, 0,  0};
    tbl[7] = '{1'b1, 4'd15, 30, 30, 1};
    tbl[8] = '{1'b1, 4'd14, 30, 28, 2};
    tbl[9] = '{1'b1, 4'd1,  30, 2,  15};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(a_pwm), 0);
    chk("rst_ps", int'(a_ps), 0);
    chk("rst_err", int'(a_err), 0);
    chk("rst_ready", int'(a_rdy), 0);
    chk("rst_ready_b", int'(b_rdy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(a_rdy), 1);

    write_a(2'd1, 4'd15, err);
    chk("err_in_range", int'(err), 0);

    // Table: write ch0 and mode, skip a period, measure one period
    foreach (tbl[k]) begin
      a_cm = tbl[k].center;
      write_a(2'd0, tbl[k].duty, err);
      sync_a("tbl_sync1");
      sync_a("tbl_sync2");
      measure_a(0, 4'd0, per, h0, h1, h2, first);
      chk($sformatf("tbl%0d_period", k), per, tbl[k].per);
      chk($sformatf("tbl%0d_high", k), h0, tbl[k].hi);
      chk($sformatf("tbl%0d_first", k), first, tbl[k].first);
      chk($sformatf("tbl%0d_ch1_full", k), h1, tbl[k].per);
    end

    // Mid-period write and write on the boundary edge (edge mode)
    a_cm = 1'b0;
    write_a(2'd0, 4'd5, err);
    sync_a("s3_sync1");
    sync_a("s3_sync2");
    measure_a(6, 4'd10, per, h0, h1, h2, first);
    chk("mid_write_keeps_old", h0, 5);
    measure_a(14, 4'd3, per, h0, h1, h2, first);
    chk("mid_write_next_period", h0, 10);
    measure_a(0, 4'd0, per, h0, h1, h2, first);
    chk("bnd_write_deferred", h0, 10);
    measure_a(0, 4'd0, per, h0, h1, h2, first);
    chk("bnd_write_applied", h0, 3);
    chk("bnd_write_period", per, 15);

    // Out-of-range channel
    write_a(2'd3, 4'd9, err);
    chk("oob_err_pulse", int'(err), 1);
    @(negedge clk);
    chk("oob_err_clear", int'(a_err), 0);
    sync_a("s4_sync1");
    sync_a("s4_sync2");
    measure_a(0, 4'd0, per, h0, h1, h2, first);
    chk("oob_ch0_kept", h0, 3);
    chk("oob_ch1_kept", h1, 15);
    chk("oob_ch2_zero", h2, 0);

    // Prescaled edge mode, then ena drop and restart
    write_b(1'b0, 4'd2);
    sync_b("s5_sync1");
    sync_b("s5_sync2");
    measure_b(per, h0);
    chk("ps3_period", per, 45);
    chk("ps3_high", h0, 6);
    @(negedge clk);
    @(negedge clk);
    chk("ps3_high_before_ena0", int'(b_pwm[0]), 1);
    b_ena = 1'b0;
    @(negedge clk);
    chk("ena0_pwm_low", int'(b_pwm), 0);
    write_b(1'b0, 4'd4);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_pwm != 0 || b_ps) cnt++;
    end
    chk("ena0_idle", cnt, 0);
    b_ena = 1'b1;
    measure_b(per, h0);
    chk("ena_rise_first_period", per, 45);
    chk("ena_rise_high", h0, 12);

    // Asynchronous reset in the middle of a high phase
    write_a(2'd0, 4'd10, err);
    sync_a("s6_sync1");
    sync_a("s6_sync2");
    repeat (3) @(negedge clk);
    chk("pre_rst_high", int'(a_pwm[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(a_pwm), 0);
    chk("async_rst_ready", int'(a_rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    psn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_pwm != 0) cnt++;
      if (a_ps) psn++;
    end
    chk("post_rst_pwm_low", cnt, 0);
    chk("post_rst_ps_count", psn, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
